// File: rtl/acc_tx_framer_if.sv
// acc_tx_framer_if: bundle of the result-side (bip) and UART-side (uart_tx)
// signals of acc_tx_framer. The master modport is the framer itself; the
// slave modport is the surrounding environment (bip + uart_tx).
interface acc_tx_framer_if #(
    parameter int NBITS_D = 16,
    parameter int DBIT    = 8
);
    logic                i_halt;
    logic [NBITS_D-1:0]  i_data;
    logic                i_tx_done;
    logic                o_tx_start;
    logic [DBIT-1:0]     o_tx_data;
    logic                o_busy;
    logic                o_frame_done;

    modport master (
        input  i_halt,
        input  i_data,
        input  i_tx_done,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_frame_done
    );

    modport slave (
        output i_halt,
        output i_data,
        output i_tx_done,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_frame_done
    );
endinterface

// File: rtl/acc_tx_framer.sv
// acc_tx_framer: on each rising edge of the halt flag, captures the result
// word and streams it LSB byte first to uart_tx through its start/done
// handshake, one byte per start pulse.
// Optional feature macro SYNC_HEADER_EN: when defined, each frame is preceded
// by the sync byte HEADER. When undefined, only the data bytes are sent.
// The captured frame is held in a shadow register of NBYTES+1 byte slots:
// slot 0 always holds HEADER and slots 1..NBYTES hold the data bytes, so
// the header build simply starts streaming at slot 0 instead of slot 1.
module acc_tx_framer #(
    parameter int              NBITS_D = 16,
    parameter int              DBIT    = 8,
    parameter logic [DBIT-1:0] HEADER  = DBIT'(8'hA5)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    acc_tx_framer_if.master bus
);

    localparam int NBYTES   = (NBITS_D + DBIT - 1) / DBIT;
    localparam int NSLOTS   = NBYTES + 1;
    localparam int FRAME_W  = NBYTES * DBIT;
    localparam int SHADOW_W = NSLOTS * DBIT;
    localparam int IDX_W    = $clog2(NBYTES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);
`ifdef SYNC_HEADER_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state_r;
    logic                halt_q_r;
    logic [IDX_W-1:0]    idx_r;
    logic [SHADOW_W-1:0] shadow_r;
    logic                tx_start_r;
    logic [DBIT-1:0]     tx_data_r;
    logic                busy_r;
    logic                frame_done_r;

    logic [FRAME_W-1:0]  data_ext_s;
    logic [SHADOW_W-1:0] capture_s;
    logic                trigger_s;
    logic                last_s;
    logic [IDX_W-1:0]    idx_inc_s;

    // Returns byte slot idx of a shadow frame (slot 0 = header slot).
    function automatic logic [DBIT-1:0] pick_byte(
        input logic [SHADOW_W-1:0] frame,
        input logic [IDX_W-1:0]    idx
    );
        logic [DBIT-1:0] result;
        result = '0;
        for (int k = 0; k < NSLOTS; k++) begin
            if (idx == IDX_W'(k)) begin
                result = frame[k*DBIT +: DBIT];
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Zero-extend the incoming result word to a whole number of bytes.
    always_comb begin
        data_ext_s                = '0;
        data_ext_s[NBITS_D-1:0]   = bus.i_data;
    end

    assign capture_s = {data_ext_s, HEADER};
    assign trigger_s = bus.i_halt & ~halt_q_r & (state_r == ST_IDLE);
    assign last_s    = (idx_r == LAST_IDX);
    assign idx_inc_s = idx_r + IDX_W'(1);

    // Halt edge detector, frame sequencer and registered UART-side outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            halt_q_r     <= 1'b0;
            idx_r        <= '0;
            shadow_r     <= '0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            halt_q_r     <= bus.i_halt;
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        // First byte goes out straight from the captured value
                        // so the start pulse lands one cycle after the edge.
                        shadow_r   <= capture_s;
                        idx_r      <= FIRST_IDX;
                        tx_data_r  <= pick_byte(capture_s, FIRST_IDX);
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SEND;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (last_s) begin
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            idx_r      <= idx_inc_s;
                            tx_data_r  <= pick_byte(shadow_r, idx_inc_s);
                            tx_start_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_tx_start   = tx_start_r;
    assign bus.o_tx_data    = tx_data_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_frame_done = frame_done_r;

endmodule

// File: tb/tb_acc_tx_framer.sv
// tb_acc_tx_framer: three framers (16-bit, 20-bit and 4-bit results) share
// the halt and reset inputs; each has its own uart_tx responder that answers
// every start pulse with a done pulse after ack_dly cycles. Transmitted bytes
// are collected per framer and compared with a byte-list model of the frame.
module tb_acc_tx_framer;

    localparam int DBIT = 8;
    localparam int NDUT = 3;
    localparam int W0   = 16;
    localparam int W1   = 20;
    localparam int W2   = 4;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst;
    logic halt;
    logic extra_done;
    logic [W0-1:0] data0;
    logic [W1-1:0] data1;
    logic [W2-1:0] data2;

    logic [NDUT-1:0] start_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] fdone_v;
    logic [NDUT-1:0] done_v;
    logic [7:0]      txd_v [NDUT];

    int      n_cmp;
    int      n_bad;
    int      ack_dly;
    int      cnt       [NDUT];
    int      frames    [NDUT];
    logic [7:0] last_byte [NDUT];
    byte_q_t got       [NDUT];
    byte_q_t exp_q     [NDUT];

    always #5 clk = ~clk;

    acc_tx_framer_if #(.NBITS_D(W0), .DBIT(DBIT)) if0 ();
    acc_tx_framer_if #(.NBITS_D(W1), .DBIT(DBIT)) if1 ();
    acc_tx_framer_if #(.NBITS_D(W2), .DBIT(DBIT)) if2 ();

    acc_tx_framer #(.NBITS_D(W0), .DBIT(DBIT)) dut0 (.i_clk(clk), .i_reset(rst), .bus(if0.master));
    acc_tx_framer #(.NBITS_D(W1), .DBIT(DBIT)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1.master));
    acc_tx_framer #(.NBITS_D(W2), .DBIT(DBIT)) dut2 (.i_clk(clk), .i_reset(rst), .bus(if2.master));

    assign if0.i_halt = halt;
    assign if1.i_halt = halt;
    assign if2.i_halt = halt;
    assign if0.i_data = data0;
    assign if1.i_data = data1;
    assign if2.i_data = data2;
    assign if0.i_tx_done = done_v[0] | extra_done;
    assign if1.i_tx_done = done_v[1];
    assign if2.i_tx_done = done_v[2];

    assign start_v = {if2.o_tx_start, if1.o_tx_start, if0.o_tx_start};
    assign busy_v  = {if2.o_busy, if1.o_busy, if0.o_busy};
    assign fdone_v = {if2.o_frame_done, if1.o_frame_done, if0.o_frame_done};
    assign txd_v[0] = if0.o_tx_data;
    assign txd_v[1] = if1.o_tx_data;
    assign txd_v[2] = if2.o_tx_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of bytes: optional sync byte, then the value LSB first.
    function automatic byte_q_t model(input int nbits, input logic [31:0] value);
        byte_q_t q;
        int nbytes;
        logic [31:0] v;
        q = {};
        nbytes = (nbits + 7) / 8;
        v = (nbits >= 32) ? value : (value & ((32'd1 << nbits) - 32'd1));
`ifdef SYNC_HEADER_EN
        q.push_back(8'hA5);
`endif
        for (int k = 0; k < nbytes; k++) q.push_back(8'((v >> (8 * k)) & 32'hFF));
        return q;
    endfunction

    // uart_tx responders and byte/frame monitors for all three framers.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                cnt[d]    <= 0;
                done_v[d] <= 1'b0;
            end else if (start_v[d]) begin
                got[d].push_back(txd_v[d]);
                last_byte[d] <= txd_v[d];
                cnt[d]       <= ack_dly;
                done_v[d]    <= 1'b0;
            end else if (cnt[d] == 1) begin
                cnt[d]    <= 0;
                done_v[d] <= 1'b1;
            end else begin
                if (cnt[d] > 0) cnt[d] <= cnt[d] - 1;
                done_v[d] <= 1'b0;
            end
            if (!rst && busy_v[d] && !start_v[d])
                chk($sformatf("hold_data%0d", d), 64'(txd_v[d]), 64'(last_byte[d]));
            if (fdone_v[d]) begin
                frames[d] <= frames[d] + 1;
                chk($sformatf("busy_at_fdone%0d", d), 64'(busy_v[d]), 64'd0);
                chk($sformatf("fdone_after_ack%0d", d), 64'(done_v[d]), 64'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Fresh rising edge of halt with new data; checks first-byte latency.
    task automatic fire(input logic [W0-1:0] a, input logic [W1-1:0] b, input logic [W2-1:0] c);
        halt = 1'b0;
        tick(2);
        for (int d = 0; d < NDUT; d++) got[d].delete();
        data0 = a;
        data1 = b;
        data2 = c;
        exp_q[0] = model(W0, 32'(a));
        exp_q[1] = model(W1, 32'(b));
        exp_q[2] = model(W2, 32'(c));
        halt = 1'b1;
        tick(1);
        chk("first_start", 64'(start_v), 64'h7);
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("first_byte%0d", d), 64'(txd_v[d]), 64'(exp_q[d][0]));
    endtask

    task automatic wait_frames(input string tag, input int target);
        int t;
        t = 0;
        while ((frames[0] < target || frames[1] < target || frames[2] < target) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, 64'(t < 4000), 64'd1);
    endtask

    task automatic check_frames(input string tag, input int nframes);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_frames%0d", tag, d), 64'(frames[d]), 64'(nframes));
            chk($sformatf("%s_len%0d", tag, d), 64'(got[d].size()), 64'(exp_q[d].size()));
            for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++)
                chk($sformatf("%s_d%0d_b%0d", tag, d, i), 64'(got[d][i]), 64'(exp_q[d][i]));
        end
        chk({tag, "_busy_low"}, 64'(busy_v), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        halt = 1'b0;
        extra_done = 1'b0;
        ack_dly = 10;
        data0 = '0;
        data1 = '0;
        data2 = '0;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) frames[d] = 0;

        // Reset state, before any clock edge.
        #1;
        chk("rst_start", 64'(start_v), 64'd0);
        chk("rst_busy", 64'(busy_v), 64'd0);
        chk("rst_fdone", 64'(fdone_v), 64'd0);
        for (int d = 0; d < NDUT; d++) chk($sformatf("rst_data%0d", d), 64'(txd_v[d]), 64'd0);
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("idle_start", 64'(start_v), 64'd0);

        // Directed values: exact bytes, 20-bit zero padding, sub-byte word.
        fire(16'h1234, 20'hABCDE, 4'(4'h9));
        wait_frames("t1", 1);
        tick(2);
        check_frames("t1", 1);

        // Halt toggling during a frame, then held high for 1000 cycles.
        fire(16'($urandom), 20'($urandom), 4'($urandom));
        tick(3);
        halt = 1'b0; tick(1);
        halt = 1'b1; tick(1);
        halt = 1'b0; tick(1);
        halt = 1'b1;
        tick(1000);
        check_frames("t2", 2);

        // Stray done while idle, then input change while the frame is in flight.
        halt = 1'b0;
        tick(2);
        for (int d = 0; d < NDUT; d++) got[d].delete();
        extra_done = 1'b1;
        tick(1);
        extra_done = 1'b0;
        tick(3);
        chk("stray_done_no_start", 64'(got[0].size()), 64'd0);
        fire(16'h1234, 20'($urandom), 4'($urandom));
        tick(4);
        data0 = 16'($urandom);
        data1 = 20'($urandom);
        data2 = 4'($urandom);
        wait_frames("t3", 3);
        tick(2);
        check_frames("t3", 3);

        // Reset while waiting for the first done: frame aborted at once.
        fire(16'($urandom), 20'($urandom), 4'($urandom));
        tick(4);
        #2;
        halt = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_start", 64'(start_v), 64'd0);
        chk("abort_busy", 64'(busy_v), 64'd0);
        chk("abort_fdone", 64'(fdone_v), 64'd0);
        for (int d = 0; d < NDUT; d++) chk($sformatf("abort_data%0d", d), 64'(txd_v[d]), 64'd0);
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        tick(30);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("abort_bytes%0d", d), 64'(got[d].size()), 64'd1);
            chk($sformatf("abort_frames%0d", d), 64'(frames[d]), 64'd3);
        end
        fire(16'hBEEF, 20'($urandom), 4'($urandom));
        wait_frames("t4", 4);
        tick(2);
        check_frames("t4", 4);

        // Random values and random uart_tx response times.
        for (int i = 0; i < 6; i++) begin
            ack_dly = int'($urandom_range(1, 12));
            fire(16'($urandom), 20'($urandom), 4'($urandom));
            wait_frames("rnd", 5 + i);
            tick(2);
            check_frames($sformatf("rnd%0d", i), 5 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
